uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; the successor to the hard-wired 8N1 bit-sniffer used on the FPGA top levels.
- Samples a serial line at a run-time baud divisor. Supports configurable data bits, parity and stop bits.
- Buffers received characters with error flags in a small FIFO behind a valid/ready interface.
- Sits between a board pin or `uart_if` txd and any consumer: LED latch, bus register block, debug monitor.

Parameters:
- DATA_BITS, 8, data bits per character; legal 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.
- DIV_W, 16, width of the baud divisor.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- div  in  DIV_W  clock cycles per bit; values below 4 are treated as 4.
- rxd  in  1  asynchronous serial input, idle high.
- out_data  out  8  received character, LSB-aligned, upper bits zero.
- out_ferr  out  1  framing error flag of the head entry.
- out_perr  out  1  parity error flag of the head entry.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept; pop when out_valid && out_ready.
- overrun  out  1  sticky: a character was dropped because the FIFO was full.
- clr_overrun  in  1  synchronous clear of overrun.
- last_good  out  8  most recent character received with no error (LED-style latch).
- busy  out  1  receiver not in IDLE.

Behaviour:
- Reset values: out_valid 0, out_data/out_ferr/out_perr 0, overrun 0, last_good 0, busy 0, FSM in IDLE.
- Reset asserted mid-frame aborts the frame immediately and empties the FIFO.
- Synchroniser:
  - rxd passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic uses the synchronised value rxs.
  - Input-to-rxs latency is 2 cycles.
- Divisor latch: div is captured into div_l on start detect. A div change mid-frame takes effect at the next frame.
- Bit counter: cnt counts 0..div_l-1.
- FSM states IDLE, START, DATA, PAR, STOP:
  - IDLE: on rxs == 0, go to START with cnt = 0.
  - START: at cnt == div_l>>1 (mid-bit), sample rxs.
    - If 1 (glitch): return to IDLE, nothing pushed.
    - Else: go to DATA with cnt = 0 and bit index = 0.
  - DATA: at cnt == div_l-1, sample rxs into shift[idx]; data is LSB first.
    - After bit DATA_BITS-1, go to PAR if PARITY != 0, else STOP.
  - PAR: sample at cnt == div_l-1.
    - perr = sampled bit XOR (XOR of data bits) XOR (PARITY == 1).
    - Odd parity: the data bits plus the parity bit contain an odd number of ones.
  - STOP: sample STOP_BITS times, each at cnt == div_l-1.
    - ferr = 1 if any stop sample is 0.
    - After the last stop sample, push {data, ferr, perr} on the next edge and return to IDLE.
    - A low stop bit does not cause re-sync on the same cycle; IDLE start detect applies from the next cycle.
- Timing: every sample falls on a mid-bit point, i.e. a multiple of div_l after the mid-start sample.
- Push with FIFO not full:
  - The entry is appended.
  - last_good updates in the same cycle only if ferr == 0 and perr == 0.
- Push with FIFO full:
  - The character is dropped and overrun is set.
  - last_good still updates if error-free.
- Push and pop in the same cycle with FIFO full: the pop takes precedence, the push succeeds and there is no overrun.
- overrun set and clr_overrun in the same cycle: set wins.
- FIFO:
  - out_* reflect the head entry, registered (first-word fall-through).
  - out_valid rises 1 cycle after a push into an empty FIFO.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- busy = (state != IDLE).

Decomposition:
- Package uart_rx_pkg:
  - enum rx_state_e {IDLE, START, DATA, PAR, STOP}.
  - Parity constants PAR_NONE / PAR_ODD / PAR_EVEN.
  - Struct rx_entry_t {data[7:0], ferr, perr}.
- Sub-module uart_rx_fifo:
  - Generic synchronous FIFO of rx_entry_t, parameter DEPTH.
  - Ports: clk, rstn, push, din, full, pop, dout, empty.
  - Reusable for the future TX side.

Test Plan:
- 8N1, div = 16:
  - Send 0xA5 -> one entry with out_data 0xA5, ferr 0, perr 0; last_good = 0xA5.
  - out_valid rises 9*16 + 8 + 2 (sync) + 2 cycles after the rxd falling edge, ±1 cycle.
- DATA_BITS = 7, PARITY = 2, div = 8:
  - Send 0x41 with correct parity bit 0 -> perr 0.
  - Send 0x41 with parity bit 1 -> perr 1, last_good unchanged.
- Framing and false start:
  - Stop bit forced 0 on 0x3C -> entry 0x3C with ferr 1.
  - Low pulse of 3 cycles at div = 16 -> no entry, FSM back to IDLE, busy deasserts.
- Overrun, FIFO_DEPTH = 4, out_ready = 0:
  - Send 0x01..0x05 -> FIFO holds 0x01..0x04, overrun = 1, last_good = 0x05.
  - Pulse clr_overrun -> overrun = 0.
- Divisor change and reset:
  - Change div 16 -> 10 mid-frame -> the current byte is decoded at 16 and the next byte at 10, both correct.
  - Assert rstn low during the DATA state -> all outputs return to reset values immediately; the following frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types for the parametrised UART receiver.
//   rx_state_e : receiver FSM states
//   PAR_*      : PARITY parameter encodings
//   rx_entry_t : one received character plus its error flags, as stored in the FIFO
//   parity_err : parity check helper
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_entry_t;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  // For odd parity the data plus parity bit must hold an odd number of ones.
  function automatic logic parity_err(input logic [7:0] data, input logic pbit,
                                      input logic odd);
    return pbit ^ (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO of rx_entry_t.
//   clk, rstn : clock, asynchronous active-low reset (empties the FIFO)
//   push, din : write request and entry; ignored when full unless popping the same cycle
//   full      : no free entry
//   pop       : read request; ignored when empty
//   dout      : head entry (zero while empty)
//   empty     : no entry stored
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      push,
  input  rx_entry_t din,
  output logic      full,
  input  logic      pop,
  output rx_entry_t dout,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rx_entry_t   mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with error-flagged receive FIFO.
//   clk, rstn      : clock, asynchronous active-low reset
//   div            : clock cycles per bit, values below 4 act as 4; latched at start detect
//   rxd            : asynchronous serial input, idle high
//   out_data/ferr/perr/valid, out_ready : FIFO head with valid/ready handshake
//   overrun, clr_overrun : sticky dropped-character flag and its synchronous clear
//   last_good      : most recent character received without error
//   busy           : receiver FSM not idle
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] div,
  input  logic             rxd,
  output logic [7:0]       out_data,
  output logic             out_ferr,
  output logic             out_perr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [7:0]       last_good,
  output logic             busy
);

  localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  // Synchroniser
  logic rx_meta_q, rxs_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // Receiver FSM
  rx_state_e        state_q;
  logic [DIV_W-1:0] cnt_q, div_l_q, div_eff;
  logic [2:0]       idx_q;
  logic             stop_q;
  logic [7:0]       shift_q;
  logic             ferr_q, perr_q;
  logic             push_q;
  rx_entry_t        push_ent_q;
  logic             mid_hit, bit_end;

  assign div_eff = (div < DIV_W'(4)) ? DIV_W'(4) : div;
  assign mid_hit = (cnt_q == (div_l_q >> 1));
  assign bit_end = (cnt_q == div_l_q - 1'b1);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_l_q    <= DIV_W'(4);
      idx_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      push_q     <= 1'b0;
      push_ent_q <= '0;
    end else begin
      push_q <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= START;
            div_l_q <= div_eff;
          end
        end
        START: begin
          if (mid_hit) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              idx_q   <= '0;
              stop_q  <= 1'b0;
              shift_q <= '0;
              ferr_q  <= 1'b0;
              perr_q  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs_q;
            if (idx_q == IDX_LAST) begin
              state_q <= (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            cnt_q   <= '0;
            perr_q  <= parity_err(shift_q, rxs_q, logic'(PARITY == PAR_ODD));
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop_q == STOP_LAST) begin
              // The entry is staged here and enters the FIFO on the next edge.
              push_q          <= 1'b1;
              push_ent_q.data <= shift_q;
              push_ent_q.ferr <= ferr_q | ~rxs_q;
              push_ent_q.perr <= perr_q;
              state_q         <= IDLE;
            end else begin
              ferr_q <= ferr_q | ~rxs_q;
              stop_q <= stop_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Receive FIFO
  rx_entry_t fifo_dout;
  logic      fifo_full, fifo_empty, pop;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_dout.data;
  assign out_ferr  = fifo_dout.ferr;
  assign out_perr  = fifo_dout.perr;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push_q),
    .din  (push_ent_q),
    .full (fifo_full),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty)
  );

  // Overrun flag and last-good latch
  logic       overrun_q;
  logic [7:0] last_good_q;

  assign overrun   = overrun_q;
  assign last_good = last_good_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun_q   <= 1'b0;
      last_good_q <= '0;
    end else begin
      // Setting has priority over a simultaneous clear.
      if (push_q && fifo_full && !pop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
      if (push_q && !push_ent_q.ferr && !push_ent_q.perr) begin
        last_good_q <= push_ent_q.data;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
  import uart_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] div8, div7;
  logic        rxd8, rxd7;
  logic [7:0]  out_data8, out_data7, last_good8, last_good7;
  logic        out_ferr8, out_perr8, out_valid8, ready8, overrun8, clr8, busy8;
  logic        out_ferr7, out_perr7, out_valid7, ready7, overrun7, clr7, busy7;

  always #5 clk = ~clk;

  uart_rx_param u_dut8 (
    .clk(clk), .rstn(rstn), .div(div8), .rxd(rxd8),
    .out_data(out_data8), .out_ferr(out_ferr8), .out_perr(out_perr8),
    .out_valid(out_valid8), .out_ready(ready8), .overrun(overrun8),
    .clr_overrun(clr8), .last_good(last_good8), .busy(busy8)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY(2)) u_dut7 (
    .clk(clk), .rstn(rstn), .div(div7), .rxd(rxd7),
    .out_data(out_data7), .out_ferr(out_ferr7), .out_perr(out_perr7),
    .out_valid(out_valid7), .out_ready(ready7), .overrun(overrun7),
    .clr_overrun(clr7), .last_good(last_good7), .busy(busy7)
  );

  int        n_vec = 0;
  int        n_err = 0;
  rx_entry_t sb8[$];
  rx_entry_t sb7[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic rx_entry_t ent(input logic [7:0] d, input logic f, input logic p);
    rx_entry_t e;
    e.data = d;
    e.ferr = f;
    e.perr = p;
    return e;
  endfunction

  // Scoreboard: compare each accepted head entry with the oldest expectation.
  always @(negedge clk) begin
    rx_entry_t e;
    if (rstn && out_valid8 && ready8) begin
      if (sb8.size() == 0) begin
        check("dut8_unexpected_entry", {24'd0, out_data8}, 32'hFFFF_FFFF);
      end else begin
        e = sb8.pop_front();
        check("dut8_data", out_data8, e.data);
        check("dut8_ferr", out_ferr8, e.ferr);
        check("dut8_perr", out_perr8, e.perr);
      end
    end
    if (rstn && out_valid7 && ready7) begin
      if (sb7.size() == 0) begin
        check("dut7_unexpected_entry", {24'd0, out_data7}, 32'hFFFF_FFFF);
      end else begin
        e = sb7.pop_front();
        check("dut7_data", out_data7, e.data);
        check("dut7_ferr", out_ferr7, e.ferr);
        check("dut7_perr", out_perr7, e.perr);
      end
    end
  end

  task automatic drive(input bit sel7, input logic v);
    if (sel7) rxd7 = v;
    else      rxd8 = v;
  endtask

  // Start bit, LSB-first data, optional parity, one stop bit, then idle.
  task automatic send(input bit sel7, input logic [7:0] data, input int nbits,
                      input bit has_par, input logic pbit, input logic stopv,
                      input int dv);
    logic [11:0] bits;
    int          n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[1+i] = data[i];
    n = 1 + nbits;
    if (has_par) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stopv;
    n++;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      drive(sel7, bits[i]);
      repeat (dv) @(posedge clk);
      #1;
    end
    drive(sel7, 1'b1);
    repeat (2 * dv) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    time t0;
    int  lat;
    bit  got;

    rstn = 1'b0;
    div8 = 16'd16;
    div7 = 16'd8;
    rxd8 = 1'b1;
    rxd7 = 1'b1;
    ready8 = 1'b1;
    ready7 = 1'b1;
    clr8 = 1'b0;
    clr7 = 1'b0;
    #1;
    check("rst_valid", out_valid8, 0);
    check("rst_data", out_data8, 0);
    check("rst_ferr", out_ferr8, 0);
    check("rst_perr", out_perr8, 0);
    check("rst_overrun", overrun8, 0);
    check("rst_last_good", last_good8, 0);
    check("rst_busy", busy8, 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk);

    // 8N1 character and output latency
    sb8.push_back(ent(8'hA5, 1'b0, 1'b0));
    got = 0;
    lat = 0;
    fork
      send(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 16);
      begin
        @(posedge clk);
        #1;
        t0 = $time;
        for (int i = 0; i < 300; i++) begin
          @(posedge clk);
          #1;
          if (out_valid8) begin
            got = 1;
            break;
          end
        end
        lat = int'(($time - 1 - t0) / 10);
        check("latency_timeout", got, 1);
        check("latency_155_157", (lat >= 155 && lat <= 157), 1);
      end
    join
    check("last_good_A5", last_good8, 8'hA5);

    // False start: 3-cycle low pulse
    @(posedge clk);
    #1;
    rxd8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_busy_high", busy8, 1);
    repeat (30) @(posedge clk);
    #1;
    check("glitch_busy_low", busy8, 0);
    check("glitch_no_entry", out_valid8, 0);

    // Framing error
    sb8.push_back(ent(8'h3C, 1'b1, 1'b0));
    send(1'b0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 16);
    check("ferr_last_good_kept", last_good8, 8'hA5);

    // 7E1 parity checks
    sb7.push_back(ent(8'h41, 1'b0, 1'b0));
    send(1'b1, 8'h41, 7, 1'b1, 1'b0, 1'b1, 8);
    check("par_last_good_41", last_good7, 8'h41);
    sb7.push_back(ent(8'h15, 1'b0, 1'b0));
    send(1'b1, 8'h15, 7, 1'b1, 1'b1, 1'b1, 8);
    check("par_last_good_15", last_good7, 8'h15);
    sb7.push_back(ent(8'h41, 1'b0, 1'b1));
    send(1'b1, 8'h41, 7, 1'b1, 1'b1, 1'b1, 8);
    check("perr_last_good_kept", last_good7, 8'h15);

    // Overrun with consumer stalled
    ready8 = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) sb8.push_back(ent(8'(v), 1'b0, 1'b0));
      send(1'b0, 8'(v), 8, 1'b0, 1'b0, 1'b1, 16);
      if (v == 4) check("ovr_not_yet", overrun8, 0);
    end
    check("ovr_set", overrun8, 1);
    check("ovr_last_good_05", last_good8, 8'h05);
    check("ovr_head_01", out_data8, 8'h01);
    clr8 = 1'b1;
    @(posedge clk);
    #1;
    clr8 = 1'b0;
    check("ovr_cleared", overrun8, 0);
    ready8 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("ovr_drained", sb8.size(), 0);
    check("ovr_empty", out_valid8, 0);

    // Divisor change mid-frame takes effect on the next frame
    sb8.push_back(ent(8'h96, 1'b0, 1'b0));
    fork
      send(1'b0, 8'h96, 8, 1'b0, 1'b0, 1'b1, 16);
      begin
        repeat (60) @(posedge clk);
        #1;
        div8 = 16'd10;
      end
    join
    check("div16_last_good", last_good8, 8'h96);
    sb8.push_back(ent(8'h5A, 1'b0, 1'b0));
    send(1'b0, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 10);
    check("div10_last_good", last_good8, 8'h5A);

    // Reset during DATA
    div8 = 16'd16;
    fork
      send(1'b0, 8'hC3, 8, 1'b0, 1'b0, 1'b1, 16);
      begin
        repeat (70) @(posedge clk);
        #1;
        check("pre_reset_busy", busy8, 1);
        rstn = 1'b0;
        #1;
        check("mid_reset_busy", busy8, 0);
        check("mid_reset_valid", out_valid8, 0);
        check("mid_reset_data", out_data8, 0);
        check("mid_reset_overrun", overrun8, 0);
        check("mid_reset_last_good", last_good8, 0);
      end
    join
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    sb8.push_back(ent(8'h3A, 1'b0, 1'b0));
    send(1'b0, 8'h3A, 8, 1'b0, 1'b0, 1'b1, 16);
    check("post_reset_last_good", last_good8, 8'h3A);

    repeat (5) @(posedge clk);
    #1;
    check("sb8_leftover", sb8.size(), 0);
    check("sb7_leftover", sb7.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
